chrono_core: RTL and testbench

Stopwatch timekeeping core for the chronometer. Clocked by the divided clock from the clock generator. Synchronises the two user buttons and runs a start/stop/lap/clear state machine. Counts elapsed time as BCD mm:ss.cc (minutes, seconds, centiseconds) and drives a registered display word to the seven-segment driver downstream.

---
 rtl/chrono_core.sv | 137 +++++++++++++
 tb/tb_chrono_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chrono_core.sv
// chrono_core: stopwatch core with button sync, start/stop/lap/clear FSM,
// BCD mm:ss.cc counter and registered display word.
module chrono_core #(
    parameter int CLK_FREQ_HZ = 5_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_lr,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        frozen,
    output logic        wrap
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);

    // Per-digit maximum, same packing as the display word.
    localparam logic [23:0] LIM = 24'h595999;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_LAP    = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [2:0]    ss_sh;
    logic [2:0]    lr_sh;
    logic          ss_ev;
    logic          lr_ev;
    logic          ev_lr;
    logic [PW-1:0] presc;
    logic [23:0]   cnt;
    logic [23:0]   cnt_nxt;
    logic [23:0]   hold;
    logic          counting;
    logic          tick;
    logic          clear;
    logic          lap_take;
    logic          carry;

    // sh[0], sh[1] synchronise; sh[2] is the previous level for edge detect.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            ss_sh <= '0;
            lr_sh <= '0;
            ss_ev <= 1'b0;
            lr_ev <= 1'b0;
        end else begin
            ss_sh <= {ss_sh[1:0], btn_ss};
            lr_sh <= {lr_sh[1:0], btn_lr};
            ss_ev <= ss_sh[1] & ~ss_sh[2];
            lr_ev <= lr_sh[1] & ~lr_sh[2];
        end
    end

    assign ev_lr    = lr_ev & ~ss_ev;
    assign counting = (state == S_RUN) || (state == S_LAP);
    assign tick     = counting && (presc == PS_MAX);
    assign clear    = (state == S_PAUSED) && ev_lr;
    assign lap_take = (state == S_RUN) && ev_lr;
    assign running  = counting;
    assign frozen   = (state == S_LAP);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ss_ev) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (ss_ev)      state_nxt = S_PAUSED;
                else if (ev_lr) state_nxt = S_LAP;
            end
            S_LAP: begin
                if (ss_ev)      state_nxt = S_PAUSED;
                else if (ev_lr) state_nxt = S_RUN;
            end
            default: begin
                if (ss_ev)      state_nxt = S_RUN;
                else if (ev_lr) state_nxt = S_IDLE;
            end
        endcase
    end

    // Ripple the carry through the digits; any digit at or above its limit
    // rolls to zero so an out-of-range value can never persist.
    always_comb begin
        cnt_nxt = cnt;
        carry   = tick;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (cnt[4*i +: 4] >= LIM[4*i +: 4]) begin
                    cnt_nxt[4*i +: 4] = 4'd0;
                end else begin
                    cnt_nxt[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (clear) cnt_nxt = '0;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            presc <= '0;
            cnt   <= '0;
            hold  <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wrap  <= tick && (cnt == LIM);
            if (clear)
                presc <= '0;
            else if (counting)
                presc <= tick ? '0 : presc + PW'(1);
            if (clear)
                hold <= '0;
            else if (lap_take)
                hold <= cnt;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            disp_bcd <= '0;
        else
            disp_bcd <= (state == S_LAP) ? hold : cnt;
    end

endmodule

// File: tb/tb_chrono_core.sv
// tb_chrono_core: scoreboard bench for chrono_core with a time-in-centiseconds
// reference model, directed scenarios and randomized button activity.
module tb_chrono_core;

    localparam int DIV  = 10;
    localparam int FULL = 360000;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_LAP    = 3;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        btn_ss;
    logic        btn_lr;
    logic [23:0] disp_bcd;
    logic        running;
    logic        frozen;
    logic        wrap;

    chrono_core #(
        .CLK_FREQ_HZ(1000),
        .TICK_HZ    (100)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .btn_ss  (btn_ss),
        .btn_lr  (btn_lr),
        .disp_bcd(disp_bcd),
        .running (running),
        .frozen  (frozen),
        .wrap    (wrap)
    );

    always #5 clk_in = ~clk_in;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [26:0] expq[$];

    int m_st;
    int m_t;
    int m_p;
    int m_h;
    bit ss_hist[$];
    bit lr_hist[$];

    logic [23:0] pre;

    function automatic logic [23:0] bcd(input int t);
        int cs;
        int s;
        int m;
        cs = t % 100;
        s  = (t / 100) % 60;
        m  = (t / 6000) % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE;
        m_t  = 0;
        m_p  = 0;
        m_h  = 0;
        ss_hist.delete();
        lr_hist.delete();
        repeat (5) begin
            ss_hist.push_back(1'b0);
            lr_hist.push_back(1'b0);
        end
    endtask

    // One clock edge of the reference: levels sampled at edge m become an
    // event acted on at edge m+3 when they rose relative to edge m-1.
    task automatic model_edge(input bit s, input bit l);
        bit          es;
        bit          el;
        bit          tk;
        bit          w;
        int          old_t;
        int          nst;
        logic [23:0] d;
        ss_hist.push_front(s);
        void'(ss_hist.pop_back());
        lr_hist.push_front(l);
        void'(lr_hist.pop_back());
        es    = ss_hist[3] && !ss_hist[4];
        el    = lr_hist[3] && !lr_hist[4] && !es;
        tk    = (m_st == M_RUN || m_st == M_LAP) && (m_p == DIV - 1);
        d     = bcd(m_st == M_LAP ? m_h : m_t);
        w     = tk && (m_t == FULL - 1);
        old_t = m_t;
        if (m_st == M_RUN || m_st == M_LAP) begin
            if (tk) begin
                m_p = 0;
                m_t = (m_t + 1) % FULL;
            end else begin
                m_p = m_p + 1;
            end
        end
        nst = m_st;
        case (m_st)
            M_IDLE: if (es) nst = M_RUN;
            M_RUN: begin
                if (es) nst = M_PAUSED;
                else if (el) begin
                    nst = M_LAP;
                    m_h = old_t;
                end
            end
            M_LAP: begin
                if (es) nst = M_PAUSED;
                else if (el) nst = M_RUN;
            end
            default: begin
                if (es) nst = M_RUN;
                else if (el) begin
                    nst = M_IDLE;
                    m_t = 0;
                    m_p = 0;
                    m_h = 0;
                end
            end
        endcase
        m_st = nst;
        expq.push_back({d, 1'(nst == M_RUN || nst == M_LAP),
                        1'(nst == M_LAP), w});
    endtask

    task automatic drive(input bit s, input bit l);
        rst    = 1'b1;
        btn_ss = s;
        btn_lr = l;
        model_edge(s, l);
    endtask

    task automatic hold(input bit s, input bit l, input int n);
        repeat (n) begin
            @(negedge clk_in);
            drive(s, l);
        end
    endtask

    task automatic chk(input string name, input logic [26:0] got,
                       input logic [26:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    // Count is overwritten only while paused, so nothing advances under it.
    task automatic preload(input int t);
        @(negedge clk_in);
        pre = bcd(t);
        force dut.cnt = pre;
        m_t = t;
        drive(1'b0, 1'b0);
        @(negedge clk_in);
        release dut.cnt;
        drive(1'b0, 1'b0);
    endtask

    initial begin
        logic [26:0] want;
        logic [26:0] got;
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                want = expq.pop_front();
                got  = {disp_bcd, running, frozen, wrap};
                total++;
                if (got === want) passed++;
                else $display("FAIL out cyc=%0d got disp=%h run=%b frz=%b wrap=%b want disp=%h run=%b frz=%b wrap=%b",
                              cyc, got[26:3], got[2], got[1], got[0],
                              want[26:3], want[2], want[1], want[0]);
            end
        end
    end

    initial begin
        int pl[3];
        bit s;
        bit l;
        pl[0] = 5995;
        pl[1] = 59995;
        pl[2] = FULL - 5;
        rst    = 1'b0;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        pre    = '0;
        model_reset();
        #2;
        chk("reset_t0", {disp_bcd, running, frozen, wrap}, 27'd0);
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_hold", {disp_bcd, running, frozen, wrap}, 27'd0);

        // start, count to 00:01.xx
        hold(0, 0, 2);
        hold(1, 0, 3);
        hold(0, 0, 1010);
        // pause, resume, lap, unlap
        hold(1, 0, 3);
        hold(0, 0, 20);
        hold(1, 0, 3);
        hold(0, 0, 37);
        hold(0, 1, 3);
        hold(0, 0, 200);
        hold(0, 1, 3);
        hold(0, 0, 50);
        // lap then pause from lap, then clear, then lr in idle
        hold(0, 1, 3);
        hold(0, 0, 30);
        hold(1, 0, 3);
        hold(0, 0, 20);
        hold(0, 1, 3);
        hold(0, 0, 10);
        hold(0, 1, 3);
        hold(0, 0, 5);

        // digit carries and full rollover from preloaded counts
        hold(1, 0, 3);
        hold(0, 0, 15);
        hold(1, 0, 3);
        hold(0, 0, 6);
        for (int i = 0; i < 3; i++) begin
            preload(pl[i]);
            hold(1, 0, 3);
            hold(0, 0, 90);
            hold(1, 0, 3);
            hold(0, 0, 6);
        end

        // both buttons together while running
        hold(1, 0, 3);
        hold(0, 0, 10);
        hold(1, 1, 50);
        hold(0, 0, 10);

        // asynchronous reset mid-run
        hold(1, 0, 3);
        hold(0, 0, 500);
        @(posedge clk_in);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst", {disp_bcd, running, frozen, wrap}, 27'd0);
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk("async_rst_hold", {disp_bcd, running, frozen, wrap}, 27'd0);
        hold(0, 0, 3);
        hold(0, 1, 3);
        hold(0, 0, 10);

        // random button activity
        s = 1'b0;
        l = 1'b0;
        repeat (8000) begin
            if ($urandom_range(0, 39) == 0) s = !s;
            if ($urandom_range(0, 39) == 0) l = !l;
            @(negedge clk_in);
            drive(s, l);
        end

        hold(0, 0, 2);
        @(posedge clk_in);
        #2;
        total++;
        if (expq.size() == 0) passed++;
        else $display("FAIL drain got=%0d want=0", expq.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
